// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch : instruction prefetch queue fed by a combinational ROM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module if_prefetch #(
  parameter int DEPTH = 4,
  parameter int PCW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic [PCW-1:0] rom_addr,
  input  logic [31:0]    rom_instr,
  input  logic           stall_i,
  input  logic           branch_i,
  input  logic           alu_zero_i,
  input  logic [PCW-1:0] pc_branch_i,
  input  logic           jmp_i,
  input  logic [PCW-1:0] pc_jmp_i,
  output logic [31:0]    instr_o,
  output logic [PCW-1:0] next_pc_o,
  output logic           valid_o,
  output logic           flush_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [PCW-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            flush_q, flush_d;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [PCW-1:0]  npc_mem_q   [DEPTH];

  logic            w_taken;
  logic            w_redirect;
  logic [PCW-1:0]  w_target;
  logic [PCW-1:0]  w_fetch_pc_inc;
  logic            w_push;
  logic            w_pop;

  assign w_taken        = branch_i && alu_zero_i;
  assign w_redirect     = w_taken || jmp_i;
  assign w_target       = w_taken ? pc_branch_i : pc_jmp_i;
  assign w_fetch_pc_inc = fetch_pc_q + PCW'(1);

  assign valid_o   = (count_q != '0);
  assign instr_o   = instr_mem_q[rd_ptr_q];
  assign next_pc_o = npc_mem_q[rd_ptr_q];
  assign rom_addr  = fetch_pc_q;
  assign flush_o   = flush_q;

  // A redirect suppresses both ends of the queue so stale entries never leak.
  assign w_pop  = valid_o && !stall_i && !w_redirect;
  assign w_push = !w_redirect && ((count_q < FULL_CNT) || w_pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    flush_d    = w_redirect;
    if (w_redirect) begin
      fetch_pc_d = w_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (w_push) begin
        fetch_pc_d = w_fetch_pc_inc;
        wr_ptr_d   = wr_ptr_q + PTRW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
    end
  end

  // Queue storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      instr_mem_q[wr_ptr_q] <= rom_instr;
      npc_mem_q[wr_ptr_q]   <= w_fetch_pc_inc;
    end
  end

endmodule

`default_nettype wire
